asm_cfg_arbiter: RTL

Two-master register-access arbiter that sits directly upstream of the accelerator-domain ASM register file. It accepts valid/ready register requests from the TCU-side configuration path (m0) and the local PicoRV32 MMIO path (m1). Accepted requests are serialised onto the single-cycle register-file port (`config_*`), and the one-cycle-latency read data is captured. Each master receives a held response with an error flag. Requests that are out of range or misaligned are rejected locally and never reach the register file.

---
 rtl/asm_cfg_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/asm_cfg_arbiter.sv
// asm_cfg_arbiter: round-robin arbiter that serialises two masters' register requests onto a single-cycle register-file port
// Ports: clk_i, reset_n_i (sync, active-low)
//        mX_req_*  : valid/ready request (wben != 0 means write, addr, wdata), X = 0/1
//        mX_resp_* : response held until taken (rdata, err)
//        config_*  : register-file strobe, byte enables, address, write data; rdata valid the cycle after en
module asm_cfg_arbiter #(
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] ADDR_LIMIT = 'h30
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         m0_req_valid_i,
  output logic                         m0_req_ready_o,
  input  logic [TCU_REG_BSEL_SIZE-1:0] m0_req_wben_i,
  input  logic [TCU_REG_ADDR_SIZE-1:0] m0_req_addr_i,
  input  logic [TCU_REG_DATA_SIZE-1:0] m0_req_wdata_i,
  output logic                         m0_resp_valid_o,
  input  logic                         m0_resp_ready_i,
  output logic [TCU_REG_DATA_SIZE-1:0] m0_resp_rdata_o,
  output logic                         m0_resp_err_o,
  input  logic                         m1_req_valid_i,
  output logic                         m1_req_ready_o,
  input  logic [TCU_REG_BSEL_SIZE-1:0] m1_req_wben_i,
  input  logic [TCU_REG_ADDR_SIZE-1:0] m1_req_addr_i,
  input  logic [TCU_REG_DATA_SIZE-1:0] m1_req_wdata_i,
  output logic                         m1_resp_valid_o,
  input  logic                         m1_resp_ready_i,
  output logic [TCU_REG_DATA_SIZE-1:0] m1_resp_rdata_o,
  output logic                         m1_resp_err_o,
  output logic                         config_en_o,
  output logic [TCU_REG_BSEL_SIZE-1:0] config_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0] config_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0] config_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0] config_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic last, gnt, err, sel, legal, idle, accept, resp_taken;
  logic [TCU_REG_DATA_SIZE-1:0] rdata;
  logic [TCU_REG_BSEL_SIZE-1:0] sel_wben;
  logic [TCU_REG_ADDR_SIZE-1:0] sel_addr;
  logic [TCU_REG_DATA_SIZE-1:0] sel_wdata;
  // On a tie the master that was not granted last wins; a lone requester always wins.
  always_comb begin
    idle = state == IDLE;
    sel = (m0_req_valid_i & m1_req_valid_i) ? ~last : m1_req_valid_i;
    accept = idle & (m0_req_valid_i | m1_req_valid_i);
    sel_wben = sel ? m1_req_wben_i : m0_req_wben_i;
    sel_addr = sel ? m1_req_addr_i : m0_req_addr_i;
    sel_wdata = sel ? m1_req_wdata_i : m0_req_wdata_i;
    legal = sel_addr < ADDR_LIMIT && sel_addr[2:0] == 3'd0;
    resp_taken = gnt ? m1_resp_ready_i : m0_resp_ready_i;
  end
  assign m0_req_ready_o = idle & m0_req_valid_i & ~sel;
  assign m1_req_ready_o = idle & m1_req_valid_i & sel;
  assign config_en_o = state == ISSUE;
  assign m0_resp_valid_o = state == RESP && !gnt;
  assign m1_resp_valid_o = state == RESP && gnt;
  assign m0_resp_rdata_o = m0_resp_valid_o ? rdata : '0;
  assign m1_resp_rdata_o = m1_resp_valid_o ? rdata : '0;
  assign m0_resp_err_o = m0_resp_valid_o & err;
  assign m1_resp_err_o = m1_resp_valid_o & err;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      last <= 1'b1;
      gnt <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      config_wben_o <= '0;
      config_addr_o <= '0;
      config_wdata_o <= '0;
    end else begin
      if (accept) begin
        last <= sel;
        gnt <= sel;
        err <= ~legal;
        rdata <= '0;
        state <= legal ? ISSUE : RESP;
        if (legal) begin
          config_wben_o <= sel_wben;
          config_addr_o <= sel_addr;
          config_wdata_o <= sel_wdata;
        end
      end
      if (state == ISSUE) state <= CAPTURE;
      if (state == CAPTURE) begin
        state <= RESP;
        rdata <= |config_wben_o ? '0 : config_rdata_i;
      end
      if (state == RESP && resp_taken) state <= IDLE;
    end
  end
endmodule
